srl_fifo16: RTL

Shallow 16-entry ready/valid FIFO built on a per-bit addressable shift register: the write side shifts words in, and the read side selects the oldest word by address. It is the reader-side counterpart of the fixed-address delay line. Instead of a fixed delay, the read address tracks occupancy, so data leaves under consumer backpressure. It sits between GEMAC RX/TX pipeline stages to absorb short stalls without block RAM.

---
 rtl/srl_fifo16.sv | 77 +++++++
 1 files changed

// File: rtl/srl_fifo16.sv
// 16-entry ready/valid FIFO on an addressable shift register: writes shift in at
// srl[0], reads select the oldest word at srl[count-1].
module srl_fifo16 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [4:0]       occupied,
  output logic [4:0]       space
);

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;
  localparam int unsigned AW    = 4;

  logic [WIDTH-1:0] srl_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [AW-1:0]    rd_idx;
  logic             wr;
  logic             rd;

  // Handshake flags depend only on registered count plus reset/clear.
  assign i_tready = !reset && !clear && (count_q != CW'(DEPTH));
  assign o_tvalid = !reset && !clear && (count_q != '0);
  assign wr       = i_tvalid && i_tready;
  assign rd       = o_tvalid && o_tready;

  assign occupied = count_q;
  assign space    = CW'(DEPTH) - count_q;

  // Oldest word sits one below the count; index wraps harmlessly when empty.
  assign rd_idx  = AW'(count_q - CW'(1));
  assign o_tdata = srl_q[rd_idx];

  always_ff @(posedge clk) begin
    if (wr) begin
      srl_q[0] <= i_tdata;
      for (int k = 1; k < DEPTH; k++) begin
        srl_q[k] <= srl_q[k-1];
      end
    end
  end

  // Simultaneous shift and read leave the address on the next-oldest word.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (wr && !rd) begin
      count_d = count_q + CW'(1);
    end else if (rd && !wr) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

`ifndef SYNTHESIS
  a_count_range: assert property (@(posedge clk) disable iff (reset)
    (count_q <= CW'(DEPTH)) && !(wr && count_q == CW'(DEPTH)) && !(rd && count_q == '0));
`endif

endmodule
